// File: rtl/ps2msx_pkg.sv
// Shared constants, state encodings and helpers for the PS/2 -> MSX key matrix.
package ps2msx_pkg;

    localparam int MSX_ROWS = 11;

    // Set 2 prefix bytes
    localparam logic [7:0] PFX_E0 = 8'hE0;
    localparam logic [7:0] PFX_F0 = 8'hF0;
    localparam logic [7:0] PFX_E1 = 8'hE1;

    // Fake shifts the keyboard wraps around some extended keys
    localparam logic [7:0] FAKE_LSH = 8'h12;
    localparam logic [7:0] FAKE_RSH = 8'h59;

    // Bytes after E1 that belong to the Pause sequence
    localparam logic [2:0] PAUSE_SKIP = 3'd7;

    typedef enum logic [1:0] {
        H_IDLE = 2'd0,
        H_CLR  = 2'd1,
        H_WAIT = 2'd2
    } hs_state_t;

    typedef enum logic [2:0] {
        D_IDLE = 3'd0,
        D_E0   = 3'd1,
        D_F0   = 3'd2,
        D_E0F0 = 3'd3,
        D_E1   = 3'd4
    } dec_state_t;

    // Keyboard status / ack bytes that never describe a key
    function automatic logic is_ignored(input logic [7:0] b);
        case (b)
            8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFC, 8'hFE, 8'hFF: is_ignored = 1'b1;
            default: is_ignored = 1'b0;
        endcase
    endfunction

    // Packs a valid keymap entry as {valid, row[3:0], col[2:0]}
    function automatic logic [7:0] km(input int r, input int c);
        km = {1'b1, 4'(r), 3'(c)};
    endfunction

endpackage

// File: rtl/ps2_msx_keymap.sv
// Combinational ROM: Set 2 scancode {ext, code} -> MSX matrix position.
module ps2_msx_keymap
    import ps2msx_pkg::*;
(
    input  logic       ext,
    input  logic [7:0] code,
    output logic       valid,
    output logic [3:0] row,
    output logic [2:0] col
);

    logic [7:0] loc;

    // Lookup; anything not listed comes back invalid
    always_comb begin
        loc = 8'h00;
        case ({ext, code})
            // row 0: 0..7
            9'h045: loc = km(0, 0);  9'h016: loc = km(0, 1);
            9'h01E: loc = km(0, 2);  9'h026: loc = km(0, 3);
            9'h025: loc = km(0, 4);  9'h02E: loc = km(0, 5);
            9'h036: loc = km(0, 6);  9'h03D: loc = km(0, 7);
            // row 1: 8 9 - ^ \ @ [ ;
            9'h03E: loc = km(1, 0);  9'h046: loc = km(1, 1);
            9'h04E: loc = km(1, 2);  9'h055: loc = km(1, 3);
            9'h05D: loc = km(1, 4);  9'h00E: loc = km(1, 5);
            9'h054: loc = km(1, 6);  9'h04C: loc = km(1, 7);
            // row 2: : ] , . / _ A B
            9'h052: loc = km(2, 0);  9'h05B: loc = km(2, 1);
            9'h041: loc = km(2, 2);  9'h049: loc = km(2, 3);
            9'h04A: loc = km(2, 4);  9'h061: loc = km(2, 5);
            9'h01C: loc = km(2, 6);  9'h032: loc = km(2, 7);
            // row 3: C..J
            9'h021: loc = km(3, 0);  9'h023: loc = km(3, 1);
            9'h024: loc = km(3, 2);  9'h02B: loc = km(3, 3);
            9'h034: loc = km(3, 4);  9'h033: loc = km(3, 5);
            9'h043: loc = km(3, 6);  9'h03B: loc = km(3, 7);
            // row 4: K..R
            9'h042: loc = km(4, 0);  9'h04B: loc = km(4, 1);
            9'h03A: loc = km(4, 2);  9'h031: loc = km(4, 3);
            9'h044: loc = km(4, 4);  9'h04D: loc = km(4, 5);
            9'h015: loc = km(4, 6);  9'h02D: loc = km(4, 7);
            // row 5: S..Z
            9'h01B: loc = km(5, 0);  9'h02C: loc = km(5, 1);
            9'h03C: loc = km(5, 2);  9'h02A: loc = km(5, 3);
            9'h01D: loc = km(5, 4);  9'h022: loc = km(5, 5);
            9'h035: loc = km(5, 6);  9'h01A: loc = km(5, 7);
            // row 6: SHIFT CTRL GRAPH CAPS CODE F1 F2 F3
            9'h012: loc = km(6, 0);  9'h059: loc = km(6, 0);
            9'h014: loc = km(6, 1);  9'h114: loc = km(6, 1);
            9'h011: loc = km(6, 2);  9'h058: loc = km(6, 3);
            9'h111: loc = km(6, 4);  9'h005: loc = km(6, 5);
            9'h006: loc = km(6, 6);  9'h004: loc = km(6, 7);
            // row 7: F4 F5 ESC TAB STOP(End) BS SELECT(PgUp) RETURN
            9'h00C: loc = km(7, 0);  9'h003: loc = km(7, 1);
            9'h076: loc = km(7, 2);  9'h00D: loc = km(7, 3);
            9'h169: loc = km(7, 4);  9'h066: loc = km(7, 5);
            9'h17D: loc = km(7, 6);  9'h05A: loc = km(7, 7);
            9'h15A: loc = km(7, 7);
            // row 8: SPACE HOME INS DEL LEFT UP DOWN RIGHT
            9'h029: loc = km(8, 0);  9'h16C: loc = km(8, 1);
            9'h170: loc = km(8, 2);  9'h171: loc = km(8, 3);
            9'h16B: loc = km(8, 4);  9'h175: loc = km(8, 5);
            9'h172: loc = km(8, 6);  9'h174: loc = km(8, 7);
            // row 9: keypad * + / 0 1 2 3 4
            9'h07C: loc = km(9, 0);  9'h079: loc = km(9, 1);
            9'h14A: loc = km(9, 2);  9'h070: loc = km(9, 3);
            9'h069: loc = km(9, 4);  9'h072: loc = km(9, 5);
            9'h07A: loc = km(9, 6);  9'h06B: loc = km(9, 7);
            // row 10: keypad 5 6 7 8 9 - . (col 6 has no PC key)
            9'h073: loc = km(10, 0); 9'h074: loc = km(10, 1);
            9'h06C: loc = km(10, 2); 9'h075: loc = km(10, 3);
            9'h07D: loc = km(10, 4); 9'h07B: loc = km(10, 5);
            9'h071: loc = km(10, 7);
            default: loc = 8'h00;
        endcase
    end

    assign valid = loc[7];
    assign row   = loc[6:3];
    assign col   = loc[2:0];

endmodule

// File: rtl/ps2_msx_keymatrix.sv
// PS/2 Set 2 scancode decoder driving the active-low MSX keyboard matrix.
module ps2_msx_keymatrix
    import ps2msx_pkg::*;
#(
    parameter int NUM_ROWS    = MSX_ROWS,
    parameter int SYNC_STAGES = 2,
    parameter int CLR_CYCLES  = 4,
    parameter int TIMEOUT     = 65535
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] ps_dout,
    input  logic       ps_drdy,
    output logic       ps_clr_drdy,
    input  logic [3:0] row_sel,
    output logic [7:0] row_data,
    output logic       evt_valid,
    output logic       evt_make,
    output logic [3:0] evt_row,
    output logic [2:0] evt_col
);

    localparam int         CW       = $clog2(CLR_CYCLES + 1);
    localparam int         TW       = $clog2(TIMEOUT + 1);
    localparam logic [4:0] ROWS_LIM = 5'(NUM_ROWS);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   drdy_s;
    hs_state_t              hs_state, hs_next;
    logic [CW-1:0]          clr_cnt;
    logic                   take;
    logic [7:0]             byte_q;
    logic                   byte_stb;
    dec_state_t             dec_state, dec_next;
    logic [2:0]             skip;
    logic [TW-1:0]          to_cnt;
    logic                   to_hit;
    logic                   key_go, key_ext, key_make;
    logic                   km_valid;
    logic [3:0]             km_row;
    logic [2:0]             km_col;
    logic [NUM_ROWS-1:0][7:0] matrix;

    // Bring the receiver's ready flag into the clk domain
    always_ff @(posedge clk) begin
        if (rst) sync_q <= '0;
        else     sync_q <= {sync_q[SYNC_STAGES-2:0], ps_drdy};
    end
    assign drdy_s = sync_q[SYNC_STAGES-1];

    // Handshake state register and clear-pulse width counter
    always_ff @(posedge clk) begin
        if (rst) begin
            hs_state <= H_IDLE;
            clr_cnt  <= '0;
        end else begin
            hs_state <= hs_next;
            clr_cnt  <= (hs_state == H_CLR) ? clr_cnt + 1'b1 : '0;
        end
    end

    // Handshake next state: level-sensitive take, then hold off until the flag drops
    always_comb begin
        hs_next = hs_state;
        case (hs_state)
            H_IDLE:  if (drdy_s) hs_next = H_CLR;
            H_CLR:   if (clr_cnt == CW'(CLR_CYCLES - 1)) hs_next = H_WAIT;
            H_WAIT:  if (!drdy_s) hs_next = H_IDLE;
            default: hs_next = H_IDLE;
        endcase
    end

    // Handshake outputs
    always_comb begin
        ps_clr_drdy = (hs_state == H_CLR);
        take        = (hs_state == H_IDLE) && drdy_s;
    end

    // Capture the byte; ps_dout is stable while the flag is high
    always_ff @(posedge clk) begin
        if (rst) begin
            byte_q   <= '0;
            byte_stb <= 1'b0;
        end else begin
            byte_stb <= take;
            if (take) byte_q <= ps_dout;
        end
    end

    // Decode state register
    always_ff @(posedge clk) begin
        if (rst) dec_state <= D_IDLE;
        else     dec_state <= dec_next;
    end

    // Pause skip counter and prefix watchdog
    always_ff @(posedge clk) begin
        if (rst) begin
            skip   <= '0;
            to_cnt <= '0;
        end else begin
            if (byte_stb && dec_state == D_IDLE && byte_q == PFX_E1) skip <= PAUSE_SKIP;
            else if (byte_stb && dec_state == D_E1)                  skip <= skip - 1'b1;
            if (byte_stb || dec_state == D_IDLE || to_hit) to_cnt <= '0;
            else                                           to_cnt <= to_cnt + 1'b1;
        end
    end
    assign to_hit = (to_cnt == TW'(TIMEOUT - 1));

    // Decode next state: advance on bytes, fall back to idle on a stalled prefix
    always_comb begin
        dec_next = dec_state;
        if (byte_stb) begin
            case (dec_state)
                D_IDLE: begin
                    if (byte_q == PFX_E0)      dec_next = D_E0;
                    else if (byte_q == PFX_F0) dec_next = D_F0;
                    else if (byte_q == PFX_E1) dec_next = D_E1;
                end
                D_E0:    dec_next = (byte_q == PFX_F0) ? D_E0F0 : D_IDLE;
                D_E1:    if (skip == 3'd1) dec_next = D_IDLE;
                default: dec_next = D_IDLE;
            endcase
        end else if (dec_state != D_IDLE && to_hit) begin
            dec_next = D_IDLE;
        end
    end

    // Decode outputs: which bytes are key events, extended or not, make or break
    always_comb begin
        key_go   = 1'b0;
        key_ext  = 1'b0;
        key_make = 1'b0;
        if (byte_stb) begin
            case (dec_state)
                D_IDLE: begin
                    key_go   = !is_ignored(byte_q) && byte_q != PFX_E0 &&
                               byte_q != PFX_F0 && byte_q != PFX_E1;
                    key_make = 1'b1;
                end
                D_E0: begin
                    key_go   = byte_q != PFX_F0 && byte_q != FAKE_LSH && byte_q != FAKE_RSH;
                    key_ext  = 1'b1;
                    key_make = 1'b1;
                end
                D_F0:    key_go = 1'b1;
                D_E0F0: begin
                    key_go  = 1'b1;
                    key_ext = 1'b1;
                end
                default: key_go = 1'b0;
            endcase
        end
    end

    ps2_msx_keymap u_keymap (
        .ext   (key_ext),
        .code  (byte_q),
        .valid (km_valid),
        .row   (km_row),
        .col   (km_col)
    );

    // Matrix update and event pulse; repeats rewrite the same bit and still report
    always_ff @(posedge clk) begin
        if (rst) begin
            matrix    <= '1;
            evt_valid <= 1'b0;
            evt_make  <= 1'b0;
            evt_row   <= '0;
            evt_col   <= '0;
        end else begin
            evt_valid <= 1'b0;
            if (key_go && km_valid && {1'b0, km_row} < ROWS_LIM) begin
                matrix[km_row][km_col] <= ~key_make;
                evt_valid <= 1'b1;
                evt_make  <= key_make;
                evt_row   <= km_row;
                evt_col   <= km_col;
            end
        end
    end

    // Registered row read; unimplemented rows read as all released
    always_ff @(posedge clk) begin
        if (rst)                          row_data <= 8'hFF;
        else if ({1'b0, row_sel} < ROWS_LIM) row_data <= matrix[row_sel];
        else                              row_data <= 8'hFF;
    end

endmodule

// File: tb/tb_ps2_msx_keymatrix.sv
// Randomized scancode traffic against a transaction-level key matrix model.
module tb_ps2_msx_keymatrix;

    localparam int CLR_CYCLES = 4;
    localparam int TIMEOUT    = 300;
    localparam int NK         = 21;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] ps_dout = 8'h00;
    logic       ps_drdy = 1'b0;
    logic       ps_clr_drdy;
    logic [3:0] row_sel = 4'd0;
    logic [7:0] row_data;
    logic       evt_valid, evt_make;
    logic [3:0] evt_row;
    logic [2:0] evt_col;

    ps2_msx_keymatrix #(
        .NUM_ROWS(11), .SYNC_STAGES(2), .CLR_CYCLES(CLR_CYCLES), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .rst(rst), .ps_dout(ps_dout), .ps_drdy(ps_drdy),
        .ps_clr_drdy(ps_clr_drdy), .row_sel(row_sel), .row_data(row_data),
        .evt_valid(evt_valid), .evt_make(evt_make), .evt_row(evt_row), .evt_col(evt_col)
    );

    always #5 clk = ~clk;

    typedef struct { bit ext; logic [7:0] code; int row; int col; } key_t;
    typedef struct { int row; int col; bit make; } evt_t;

    int         total = 0;
    int         bad = 0;
    int         clr_rises = 0;
    int         hi_cnt = 0;
    logic [7:0] mdl[16];
    key_t       keys[NK];
    evt_t       exp_q[$];
    evt_t       mon_e;
    logic [7:0] ign[7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Checks every clear pulse width and every matrix event against the model
    always @(negedge clk) begin
        if (rst) begin
            hi_cnt = 0;
        end else begin
            if (ps_clr_drdy) begin
                if (hi_cnt == 0) clr_rises++;
                hi_cnt++;
            end else if (hi_cnt != 0) begin
                chk("clr_width", hi_cnt, CLR_CYCLES);
                hi_cnt = 0;
            end
            if (evt_valid) begin
                chk("evt_expected", exp_q.size() > 0, 1);
                if (exp_q.size() > 0) begin
                    mon_e = exp_q.pop_front();
                    chk("evt_row", evt_row, mon_e.row);
                    chk("evt_col", evt_col, mon_e.col);
                    chk("evt_make", evt_make, mon_e.make);
                end
            end
        end
    end

    task automatic model_reset();
        for (int r = 0; r < 16; r++) mdl[r] = 8'hFF;
        exp_q.delete();
    endtask

    // Receiver emulation: present a byte, drop the flag when the clear arrives
    task automatic send_byte(input logic [7:0] b);
        int n;
        @(negedge clk);
        ps_dout = b;
        ps_drdy = 1'b1;
        n = 0;
        while (!ps_clr_drdy && n < 50) begin @(negedge clk); n++; end
        chk("clr_seen", ps_clr_drdy, 1);
        ps_drdy = 1'b0;
        n = 0;
        while (ps_clr_drdy && n < 50) begin @(negedge clk); n++; end
        repeat (2) @(negedge clk);
    endtask

    task automatic expect_key(input int k, input bit make);
        evt_t e;
        if (keys[k].row >= 0) begin
            e.row = keys[k].row; e.col = keys[k].col; e.make = make;
            exp_q.push_back(e);
            mdl[keys[k].row][keys[k].col] = !make;
        end
    endtask

    task automatic do_make(input int k);
        expect_key(k, 1'b1);
        if (keys[k].ext) send_byte(8'hE0);
        send_byte(keys[k].code);
    endtask

    task automatic do_break(input int k);
        expect_key(k, 1'b0);
        if (keys[k].ext) send_byte(8'hE0);
        send_byte(8'hF0);
        send_byte(keys[k].code);
    endtask

    task automatic send_pause();
        logic [7:0] seq[8];
        seq = '{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77};
        for (int i = 0; i < 8; i++) send_byte(seq[i]);
    endtask

    task automatic read_rows();
        for (int r = 0; r < 16; r++) begin
            @(negedge clk); row_sel = 4'(r);
            @(negedge clk); chk($sformatf("row%0d", r), row_data, mdl[r]);
        end
    endtask

    task automatic read_lit(input string nm, input int r, input logic [7:0] v);
        @(negedge clk); row_sel = 4'(r);
        @(negedge clk); chk(nm, row_data, v);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, bad=%0d", bad + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        int rises0, t, k, n;
        keys[0]  = '{0, 8'h1C, 2, 6};   // A
        keys[1]  = '{0, 8'h32, 2, 7};   // B
        keys[2]  = '{0, 8'h21, 3, 0};   // C
        keys[3]  = '{0, 8'h45, 0, 0};   // 0
        keys[4]  = '{0, 8'h16, 0, 1};   // 1
        keys[5]  = '{0, 8'h12, 6, 0};   // left shift
        keys[6]  = '{0, 8'h14, 6, 1};   // ctrl
        keys[7]  = '{0, 8'h29, 8, 0};   // space
        keys[8]  = '{0, 8'h5A, 7, 7};   // return
        keys[9]  = '{0, 8'h76, 7, 2};   // esc
        keys[10] = '{1, 8'h75, 8, 5};   // up
        keys[11] = '{1, 8'h72, 8, 6};   // down
        keys[12] = '{1, 8'h6B, 8, 4};   // left
        keys[13] = '{1, 8'h74, 8, 7};   // right
        keys[14] = '{1, 8'h70, 8, 2};   // ins
        keys[15] = '{0, 8'h1A, 5, 7};   // Z
        keys[16] = '{0, 8'h7C, 9, 0};   // keypad *
        keys[17] = '{0, 8'h73, 10, 0};  // keypad 5
        keys[18] = '{0, 8'h75, 10, 3};  // keypad 8 (same code as up, not extended)
        keys[19] = '{0, 8'h07, -1, 0};  // F12, no MSX key
        keys[20] = '{1, 8'h1F, -1, 0};  // left GUI, no MSX key
        ign = '{8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFC, 8'hFE, 8'hFF};
        model_reset();

        // reset state
        repeat (3) @(negedge clk);
        chk("rst_clr", ps_clr_drdy, 0);
        chk("rst_row_data", row_data, 8'hFF);
        chk("rst_evt_valid", evt_valid, 0);
        chk("rst_evt_fields", {evt_make, evt_row, evt_col}, 0);
        rst = 1'b0;
        read_rows();

        // A make / break
        rises0 = clr_rises;
        do_make(0);
        chk("A_clr_pulses", clr_rises - rises0, 1);
        read_lit("A_make_row2", 2, 8'hBF);
        do_break(0);
        read_lit("A_break_row2", 2, 8'hFF);

        // Up, fake-shift wrapped repeat, release
        do_make(10);
        read_lit("up_row8", 8, 8'hDF);
        send_byte(8'hE0); send_byte(8'h12);
        do_make(10);
        read_lit("fake_shift_row6", 6, 8'hFF);
        read_lit("up_repeat_row8", 8, 8'hDF);
        do_break(10);
        read_lit("up_break_row8", 8, 8'hFF);

        // shift + space, then Pause must change nothing
        do_make(5);
        do_make(7);
        read_lit("shift_row6", 6, 8'hFE);
        read_lit("space_row8", 8, 8'hFE);
        send_pause();
        read_rows();

        // stalled F0 prefix times out; next byte is a plain make
        send_byte(8'hF0);
        repeat (TIMEOUT + 5) @(negedge clk);
        do_make(3);
        read_lit("timeout_row0", 0, 8'hFE);

        // random traffic
        for (int i = 0; i < 90; i++) begin
            t = $urandom_range(0, 10);
            k = $urandom_range(0, NK - 1);
            if (t < 5)       do_make(k);
            else if (t < 8)  do_break(k);
            else if (t == 8) begin send_byte(8'hE0); send_byte($urandom_range(0, 1) ? 8'h12 : 8'h59); end
            else if (t == 9) send_byte(ign[$urandom_range(0, 6)]);
            else             send_pause();
            repeat ($urandom_range(0, 3)) @(negedge clk);
            if (i % 15 == 14) read_rows();
        end
        read_rows();
        chk("queue_drained", exp_q.size(), 0);

        // flag already high while reset releases: consumed exactly once
        @(negedge clk);
        rst = 1'b1;
        ps_dout = 8'h32;
        ps_drdy = 1'b1;
        repeat (3) @(negedge clk);
        model_reset();
        expect_key(1, 1'b1);
        rises0 = clr_rises;
        rst = 1'b0;
        n = 0;
        while (!ps_clr_drdy && n < 50) begin @(negedge clk); n++; end
        chk("pending_clr_seen", ps_clr_drdy, 1);
        ps_drdy = 1'b0;
        repeat (20) @(negedge clk);
        chk("pending_one_byte", clr_rises - rises0, 1);
        read_lit("pending_B_row2", 2, 8'h7F);
        chk("pending_evt_seen", exp_q.size(), 0);

        // reset in the middle of a clear pulse
        @(negedge clk);
        ps_dout = 8'h1C;
        ps_drdy = 1'b1;
        n = 0;
        while (!ps_clr_drdy && n < 50) begin @(negedge clk); n++; end
        chk("midclr_seen", ps_clr_drdy, 1);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("midclr_drop", ps_clr_drdy, 0);
        ps_drdy = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        read_rows();
        chk("final_queue", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
